seg_disp_arbiter: RTL and testbench

SEG_DISP_ARBITER -- requirements
Module: seg_disp_arbiter

---
 rtl/seg_disp_arbiter.sv | 120 ++++++++++++
 tb/tb_seg_disp_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg_disp_arbiter.sv
// Round-robin arbiter sharing one seg7x16 display among three requesters.
// A blank gap is inserted between owners, and a hold limit applies only while another requester waits.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; display blanked and waiting for any request
// BUSY  | one requester owns the display; its word is passed through
// GAP   | GAP_CYC blank cycles between owners; requests not sampled
module seg_disp_arbiter #(
  parameter int MAX_HOLD = 200000000,
  parameter int GAP_CYC  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [63:0] data0,
  input  logic [63:0] data1,
  input  logic [63:0] data2,
  input  logic [2:0]  mode,
  output logic [2:0]  gnt,
  output logic [63:0] disp_data,
  output logic        disp_mode,
  output logic [1:0]  owner_id,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [31:0] HOLD_LAST = 32'(MAX_HOLD - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);
  localparam logic [63:0] BLANK     = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [1:0]  NO_OWNER  = 2'd3;

  logic [1:0]  state;
  logic [31:0] hold_cnt;
  logic [31:0] gap_cnt;
  logic [1:0]  last;

  logic [1:0]  nxt1;
  logic [1:0]  nxt2;
  logic [1:0]  win;
  logic [2:0]  win_oh;
  logic        owner_req;
  logic        other_req;
  logic        start_busy;
  logic        leave_busy;
  logic [63:0] owner_data;
  logic        owner_mode;

  // Search order last+1, last+2, last; last+2 mod 3 equals last-1.
  always_comb begin
    nxt1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
    nxt2 = (last == 2'd0) ? 2'd2 : last - 2'd1;
    if (req[nxt1])      win = nxt1;
    else if (req[nxt2]) win = nxt2;
    else                win = last;
    win_oh = 3'b001 << win;
  end

  // gnt is one-hot of the owner while BUSY, so it masks the owner's bits.
  always_comb begin
    owner_req  = |(req & gnt);
    other_req  = |(req & ~gnt);
    owner_mode = |(mode & gnt);
    case (owner_id)
      2'd0:    owner_data = data0;
      2'd1:    owner_data = data1;
      default: owner_data = data2;
    endcase
  end

  always_comb begin
    start_busy = (|req) && ((state == ST_IDLE) ||
                            (state == ST_GAP && gap_cnt == 32'd0));
    leave_busy = (state == ST_BUSY) &&
                 (!owner_req || (hold_cnt == HOLD_LAST && other_req));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt       <= 3'b000;
      disp_data <= BLANK;
      disp_mode <= 1'b1;
      owner_id  <= NO_OWNER;
      busy      <= 1'b0;
      hold_cnt  <= 32'd0;
      gap_cnt   <= 32'd0;
      last      <= 2'd2;
    end else if (start_busy) begin
      state    <= ST_BUSY;
      gnt      <= win_oh;
      owner_id <= win;
      last     <= win;
      busy     <= 1'b1;
      hold_cnt <= 32'd0;
    end else if (leave_busy) begin
      state     <= ST_GAP;
      gnt       <= 3'b000;
      disp_data <= BLANK;
      disp_mode <= 1'b1;
      owner_id  <= NO_OWNER;
      busy      <= 1'b0;
      gap_cnt   <= GAP_LAST;
    end else if (state == ST_BUSY) begin
      disp_data <= owner_data;
      disp_mode <= owner_mode;
      // Saturate so an uncontested owner keeps the display indefinitely.
      if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 32'd1;
    end else if (state == ST_GAP) begin
      if (gap_cnt == 32'd0) state <= ST_IDLE;
      else                  gap_cnt <= gap_cnt - 32'd1;
    end else begin
      state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench for seg_disp_arbiter with MAX_HOLD=8, GAP_CYC=2.
module tb_seg_disp_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [63:0] dat [3];
  logic [2:0]  mode;
  logic [2:0]  gnt;
  logic [63:0] disp_data;
  logic        disp_mode;
  logic [1:0]  owner_id;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [63:0] BLANK = 64'hFFFF_FFFF_FFFF_FFFF;

  seg_disp_arbiter #(.MAX_HOLD(8), .GAP_CYC(2)) dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(dat[0]), .data1(dat[1]), .data2(dat[2]), .mode(mode),
    .gnt(gnt), .disp_data(disp_data), .disp_mode(disp_mode),
    .owner_id(owner_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'd0);
    chk({tag, "_data"}, disp_data, BLANK);
    chk({tag, "_mode"}, 64'(disp_mode), 64'd1);
    chk({tag, "_owner"}, 64'(owner_id), 64'd3);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 3'b000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int exp_own [4];
    logic [2:0] exp_gnt;
    exp_own = '{0, 1, 2, 0};
    dat[0] = 64'h0000_0000_1234_5678;
    dat[1] = 64'hAAAA_BBBB_CCCC_DDDD;
    dat[2] = 64'h0123_4567_89AB_CDEF;
    mode   = 3'b000;

    // Reset values and first grant
    do_reset();
    chk_blank("rst");
    req = 3'b001;
    tick();
    chk("g0_gnt", 64'(gnt), 64'b001);
    chk("g0_busy", 64'(busy), 64'd1);
    chk("g0_owner", 64'(owner_id), 64'd0);
    tick();
    chk("g0_data", disp_data, 64'h0000_0000_1234_5678);
    chk("g0_mode", 64'(disp_mode), 64'd0);
    dat[0] = 64'hDEAD_BEEF_0000_0001;
    dat[1] = 64'h5555_5555_5555_5555;
    mode   = 3'b010;
    tick();
    chk("lat_data", disp_data, 64'hDEAD_BEEF_0000_0001);
    chk("lat_mode", 64'(disp_mode), 64'd0);
    req = 3'b000;
    tick();
    chk_blank("rel_gap1");
    tick();
    chk_blank("rel_gap2");
    tick();
    chk_blank("rel_idle");

    // Round robin 0,1,2,0 with two blank cycles between owners
    dat[0] = 64'h0000_0000_1234_5678;
    dat[1] = 64'hAAAA_BBBB_CCCC_DDDD;
    mode   = 3'b010;
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      exp_gnt = 3'b001 << exp_own[i];
      tick();
      chk("rr_gnt", 64'(gnt), 64'(exp_gnt));
      chk("rr_owner", 64'(owner_id), 64'(exp_own[i]));
      tick();
      chk("rr_data", disp_data, dat[exp_own[i]]);
      chk("rr_mode", 64'(disp_mode), 64'(mode[exp_own[i]]));
      tick();
      chk("rr_hold", 64'(gnt), 64'(exp_gnt));
      req[exp_own[i]] = 1'b0;
      tick();
      chk_blank("rr_gap1");
      req[exp_own[i]] = 1'b1;
      tick();
      chk_blank("rr_gap2");
    end

    // Timeout: owner 0 held, requester 1 waiting from BUSY cycle 2
    do_reset();
    req = 3'b001;
    tick();
    chk("to_gnt0", 64'(gnt), 64'b001);
    for (int i = 1; i < 8; i++) begin
      tick();
      if (i == 1) req = 3'b011;
      chk("to_hold", 64'(gnt), 64'b001);
    end
    tick();
    chk_blank("to_gap1");
    tick();
    chk_blank("to_gap2");
    tick();
    chk("to_gnt1", 64'(gnt), 64'b010);
    chk("to_owner1", 64'(owner_id), 64'd1);

    // Lone requester keeps grant; counter saturates
    do_reset();
    req = 3'b100;
    tick();
    chk("sat_gnt0", 64'(gnt), 64'b100);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("sat_gnt", 64'(gnt), 64'b100);
    end
    chk("sat_cnt", 64'(dut.hold_cnt), 64'd7);
    req = 3'b101;
    tick();
    chk_blank("sat_gap1");
    tick();
    tick();
    chk("sat_next", 64'(gnt), 64'b001);

    // Reset mid-BUSY with owner 1
    do_reset();
    req = 3'b010;
    tick();
    chk("mr_gnt1", 64'(gnt), 64'b010);
    tick();
    chk("mr_data1", disp_data, dat[1]);
    rst = 1'b1;
    tick();
    chk_blank("mr_rst");
    rst = 1'b0;
    req = 3'b111;
    tick();
    chk("mr_gnt0", 64'(gnt), 64'b001);
    chk("mr_owner0", 64'(owner_id), 64'd0);

    // Pulse inside GAP is ignored
    do_reset();
    req = 3'b001;
    tick();
    tick();
    req = 3'b000;
    tick();
    chk_blank("gp_gap1");
    req = 3'b010;
    tick();
    chk_blank("gp_gap2");
    req = 3'b000;
    tick();
    chk_blank("gp_idle1");
    tick();
    chk_blank("gp_idle2");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
